wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the MyProc2 five-stage pipeline, directly downstream of MEM. It latches MEM's results into the MEM/WB pipeline register and drives the register file's single write port. It decodes the retiring instruction to choose between ALU result and load data, raises the processor `halt` output when a HALT retires, and keeps a retired-instruction count.

## Interface
- `WIDTH`, 32: datapath width; PC is `WIDTH-2` bits.
- `REG_ADDR_LEN`, 5: register address width.
- `OPC_LEN`, 6: opcode field width, located at `IR[WIDTH-1 -: OPC_LEN]`.
- `OP_NOP`, 6'h00: no-op opcode.
- `OP_LOAD`, 6'h01: load opcode; writes `LMD_in`.
- `OP_STORE`, 6'h02: store opcode; no register write.
- `OP_BRANCH`, 6'h03: branch opcode; no register write.
- `OP_HALT`, 6'h3F: halt opcode.
- `CNT_W`, 32: retire counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  MEM presents a valid instruction this cycle.
- `ready_out`  out  1  stage accepts input; 0 once halted.
- `PC_in`  in  WIDTH-2  PC of the instruction from MEM.
- `IR_in`  in  WIDTH  instruction word from MEM.
- `Z_in`  in  WIDTH  ALU result from MEM.
- `LMD_in`  in  WIDTH  load data from MEM.
- `Wt_en`  out  1  register-file write enable.
- `Wt_addr`  out  REG_ADDR_LEN  register-file write address; the rd field.
- `Wt_data`  out  WIDTH  register-file write data.
- `PC_out`  out  WIDTH-2  PC of the instruction held in the stage, for debug.
- `halt`  out  1  processor halted; sticky.
- `retire_cnt`  out  CNT_W  count of retired instructions.

## Operation
- **Field decode.**
  - rd = `IR[WIDTH-OPC_LEN-1 -: REG_ADDR_LEN]`.
  - Writing class = every opcode except NOP, STORE, BRANCH and HALT.
- **FSM states.** RUN and HALTED.
  - RUN: `ready_out`=1. A handshake is `valid_in & ready_out`.
  - RUN → HALTED: on a handshake whose opcode is OP_HALT.
  - HALTED: absorbing; it is left only by `rst`.
- **Stage register.** Holds `{v, PC, IR, Z, LMD}`.
  - On a handshake with a non-HALT opcode: load all fields and set v=1.
  - Otherwise: clear v=0. This covers no handshake, a HALT capture, and the HALTED state.
- **Write port.** Combinational from the stage register.
  - `Wt_en` = v & writing class & (rd != 0). r0 is never written.
  - `Wt_data` = LMD if the opcode is OP_LOAD, else Z.
  - `Wt_addr` = rd, even when `Wt_en`=0.
- **Retire counter.**
  - `retire_cnt` increments by 1 on each handshake whose opcode is not NOP and not HALT.
  - Stores and branches count.
  - Wraps modulo 2^CNT_W with no saturation.
- **Halt.**
  - `halt` = (state == HALTED).
  - Inputs arriving after a HALT are ignored: not latched and not counted. MEM may keep driving `valid_in`.

## Timing
- **Reset values.** While `rst`=1, and immediately on assertion (asynchronous):
  - state=RUN, v=0.
  - `Wt_en`=0, `Wt_addr`=0, `Wt_data`=0, `PC_out`=0.
  - `halt`=0, `retire_cnt`=0, `ready_out`=1.
  - All stage-register data fields clear to 0.
- **Reset mid-operation.** A write pending in the stage register is dropped. The register file sees `Wt_en`=0 at the next edge.
- **Latency.**
  - An instruction is accepted at edge N.
  - `Wt_*` are valid throughout cycle N+1.
  - The register file commits at edge N+1.
  - `retire_cnt` shows the increment from edge N onward.
- **Throughput.** One instruction per cycle. No back-pressure in RUN.
- **HALT capture.**
  - HALT is accepted at edge N.
  - From edge N: `halt`=1 and `ready_out`=0.
  - The instruction accepted at edge N-1 still writes during cycle N, because HALT does not suppress older writes.
  - From edge N: v=0.
- **Simultaneous events.**
  - `valid_in` with a HALT opcode while already HALTED: no effect.
  - `rst` asserted on the same edge as a handshake: reset wins.
- **Counter wrap.** `retire_cnt` = 2^CNT_W-1 plus one retire gives 0 at the next edge.

## Test plan
- **ALU writeback.** Reset, then one valid ALU instruction with rd=5 and Z=0x12345678 → in the next cycle `Wt_en`=1, `Wt_addr`=5, `Wt_data`=0x12345678, `retire_cnt`=1.
- **Load vs. r0.**
  - Load with rd=3, Z=0xAAAA0000, LMD=0xDEADBEEF → `Wt_data`=0xDEADBEEF.
  - The same load with rd=0 → `Wt_en`=0, and `retire_cnt` still increments.
- **Non-writing opcodes.** Back-to-back STORE, BRANCH, NOP → `Wt_en`=0 all three cycles; `retire_cnt` goes up by 2 (NOP not counted).
- **Halt.**
  - Sequence: ALU (rd=7), then HALT, then ALU (rd=8) with `valid_in` held high.
  - Required: the rd=7 write occurs.
  - `halt`=1 and `ready_out`=0 from the HALT edge.
  - The rd=8 instruction is never written.
  - `retire_cnt`=1 and stays at 1 over the next 10 cycles.
- **Async reset.**
  - Assert `rst` mid-cycle while the stage holds a write to rd=4 → `Wt_en` drops to 0 without waiting for a clock edge; all outputs take their reset values.
  - After HALTED, `rst` returns the state to RUN with `ready_out`=1.
- **Wrap.** Force `retire_cnt` to 0xFFFFFFFF through prior retires or a bench backdoor, then one ALU retire → `retire_cnt`=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: captures MEM results, drives the register-file write port,
// counts retired instructions and stops accepting work once a HALT retires.
module wb_stage #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       REG_ADDR_LEN = 5,
    parameter int unsigned       OPC_LEN      = 6,
    parameter logic [OPC_LEN-1:0] OP_NOP      = 6'h00,
    parameter logic [OPC_LEN-1:0] OP_LOAD     = 6'h01,
    parameter logic [OPC_LEN-1:0] OP_STORE    = 6'h02,
    parameter logic [OPC_LEN-1:0] OP_BRANCH   = 6'h03,
    parameter logic [OPC_LEN-1:0] OP_HALT     = 6'h3F,
    parameter int unsigned       CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [WIDTH-3:0]        PC_in,
    input  logic [WIDTH-1:0]        IR_in,
    input  logic [WIDTH-1:0]        Z_in,
    input  logic [WIDTH-1:0]        LMD_in,
    output logic                    Wt_en,
    output logic [REG_ADDR_LEN-1:0] Wt_addr,
    output logic [WIDTH-1:0]        Wt_data,
    output logic [WIDTH-3:0]        PC_out,
    output logic                    halt,
    output logic [CNT_W-1:0]        retire_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                  state;
    logic [OPC_LEN-1:0]      opc_c;
    logic [REG_ADDR_LEN-1:0] rd_c;
    logic                    is_halt_c;
    logic                    writes_c;
    logic                    counts_c;
    logic                    unused_ir_c;

    // Decode of the instruction presented by MEM.
    always_comb begin
        opc_c     = IR_in[WIDTH-1 -: OPC_LEN];
        rd_c      = IR_in[WIDTH-OPC_LEN-1 -: REG_ADDR_LEN];
        is_halt_c = (opc_c == OP_HALT);
        writes_c  = !((opc_c == OP_NOP) || (opc_c == OP_STORE) ||
                      (opc_c == OP_BRANCH) || is_halt_c);
        counts_c  = !((opc_c == OP_NOP) || is_halt_c);
    end

    assign unused_ir_c = ^IR_in[WIDTH-OPC_LEN-REG_ADDR_LEN-1:0];

    // Stage register holds the write port pre-decoded, so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ready_out  <= 1'b1;
            halt       <= 1'b0;
            Wt_en      <= 1'b0;
            Wt_addr    <= '0;
            Wt_data    <= '0;
            PC_out     <= '0;
            retire_cnt <= '0;
        end else begin
            Wt_en <= 1'b0;
            case (state)
                RUN: begin
                    if (valid_in) begin
                        if (is_halt_c) begin
                            state     <= HALTED;
                            ready_out <= 1'b0;
                            halt      <= 1'b1;
                        end else begin
                            Wt_en   <= writes_c && (rd_c != '0);
                            Wt_addr <= rd_c;
                            Wt_data <= (opc_c == OP_LOAD) ? LMD_in : Z_in;
                            PC_out  <= PC_in;
                        end
                        if (counts_c) begin
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_stage;

    localparam logic [5:0] ALU = 6'h04;
    localparam logic [5:0] LD  = 6'h01;
    localparam logic [5:0] ST  = 6'h02;
    localparam logic [5:0] BR  = 6'h03;
    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] HLT = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [29:0] PC_in = '0;
    logic [31:0] IR_in = '0;
    logic [31:0] Z_in = '0;
    logic [31:0] LMD_in = '0;

    logic        ready_out, Wt_en, halt;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data, retire_cnt;
    logic [29:0] PC_out;

    logic        s_ready, s_Wt_en, s_halt;
    logic [4:0]  s_Wt_addr;
    logic [31:0] s_Wt_data;
    logic [29:0] s_PC_out;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;
    logic [29:0] pc_ctr = 30'h100;

    wb_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .PC_in(PC_in), .IR_in(IR_in), .Z_in(Z_in), .LMD_in(LMD_in),
        .Wt_en(Wt_en), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .PC_out(PC_out),
        .halt(halt), .retire_cnt(retire_cnt)
    );

    // Narrow-counter instance so the wrap is reached with a handful of retires.
    wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(s_ready),
        .PC_in(PC_in), .IR_in(IR_in), .Z_in(Z_in), .LMD_in(LMD_in),
        .Wt_en(s_Wt_en), .Wt_addr(s_Wt_addr), .Wt_data(s_Wt_data), .PC_out(s_PC_out),
        .halt(s_halt), .retire_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the last accepted instruction plus halted flag and retire total.
    logic        m_halted = 1'b0;
    logic        m_v = 1'b0;
    logic [29:0] m_pc = '0;
    logic [31:0] m_ir = '0;
    logic [31:0] m_z = '0;
    logic [31:0] m_lmd = '0;
    logic [31:0] m_cnt = '0;
    logic        m_hs;
    logic [5:0]  m_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_halted = 1'b0; m_v = 1'b0; m_pc = '0; m_ir = '0;
            m_z = '0; m_lmd = '0; m_cnt = '0;
        end else begin
            m_hs = valid_in && !m_halted;
            m_op = IR_in[31:26];
            m_v  = 1'b0;
            if (m_hs) begin
                if (m_op == HLT) begin
                    m_halted = 1'b1;
                end else begin
                    m_v = 1'b1; m_pc = PC_in; m_ir = IR_in; m_z = Z_in; m_lmd = LMD_in;
                end
                if (m_op != NOP && m_op != HLT) m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        e_en;
        logic [31:0] e_data;
        op     = m_ir[31:26];
        rd     = m_ir[25:21];
        e_en   = m_v && !(op == NOP || op == ST || op == BR || op == HLT) && (rd != 0);
        e_data = (op == LD) ? m_lmd : m_z;
        chk("ready_out", 32'(ready_out), 32'(!m_halted));
        chk("halt", 32'(halt), 32'(m_halted));
        chk("Wt_en", 32'(Wt_en), 32'(e_en));
        chk("Wt_addr", 32'(Wt_addr), 32'(rd));
        chk("Wt_data", Wt_data, e_data);
        chk("PC_out", 32'(PC_out), 32'(m_pc));
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("small_cnt", 32'(s_cnt), 32'(m_cnt[3:0]));
        chk("small_port", {s_ready, s_halt, s_Wt_en, s_Wt_addr, s_Wt_data[23:0]},
            {ready_out, halt, Wt_en, Wt_addr, Wt_data[23:0]});
        chk("small_pc", 32'(s_PC_out), 32'(PC_out));
    end

    task automatic send(input logic v, input logic [5:0] opc, input logic [4:0] rd,
                        input logic [31:0] z, input logic [31:0] lmd);
        valid_in = v;
        IR_in    = {opc, rd, 21'h0A5A5};
        Z_in     = z;
        LMD_in   = lmd;
        PC_in    = pc_ctr;
        pc_ctr   = pc_ctr + 30'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_Wt_en", 32'(Wt_en), 32'h0);
        chk("rst_ready", 32'(ready_out), 32'h1);
        chk("rst_cnt", retire_cnt, 32'h0);
        rst = 1'b0;

        send(1'b1, ALU, 5'd5, 32'h12345678, 32'h0);
        chk("alu_en", 32'(Wt_en), 32'h1);
        chk("alu_addr", 32'(Wt_addr), 32'h5);
        chk("alu_data", Wt_data, 32'h12345678);
        chk("alu_cnt", retire_cnt, 32'h1);

        send(1'b1, LD, 5'd3, 32'hAAAA0000, 32'hDEADBEEF);
        chk("ld_en", 32'(Wt_en), 32'h1);
        chk("ld_data", Wt_data, 32'hDEADBEEF);
        send(1'b1, LD, 5'd0, 32'hAAAA0000, 32'hDEADBEEF);
        chk("ld_r0_en", 32'(Wt_en), 32'h0);
        chk("ld_r0_cnt", retire_cnt, 32'h3);

        send(1'b1, ST, 5'd6, 32'h1, 32'h2);
        chk("st_en", 32'(Wt_en), 32'h0);
        send(1'b1, BR, 5'd6, 32'h3, 32'h4);
        chk("br_en", 32'(Wt_en), 32'h0);
        send(1'b1, NOP, 5'd6, 32'h5, 32'h6);
        chk("nop_en", 32'(Wt_en), 32'h0);
        chk("nonwr_cnt", retire_cnt, 32'h5);

        for (int i = 0; i < 12; i++) begin
            send(1'b1, ALU, 5'(i + 1), 32'h1000 + 32'(i), 32'hFFFF0000);
            if (i == 10) chk("small_wrap", 32'(s_cnt), 32'h0);
        end
        chk("burst_cnt", retire_cnt, 32'd17);
        chk("small_after", 32'(s_cnt), 32'h1);
        send(1'b0, ALU, 5'd9, 32'h9, 32'h9);
        chk("idle_en", 32'(Wt_en), 32'h0);
        chk("idle_cnt", retire_cnt, 32'd17);

        send(1'b1, ALU, 5'd4, 32'h44, 32'h0);
        chk("pre_rst_en", 32'(Wt_en), 32'h1);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 32'(Wt_en), 32'h0);
        chk("arst_addr", 32'(Wt_addr), 32'h0);
        chk("arst_data", Wt_data, 32'h0);
        chk("arst_pc", 32'(PC_out), 32'h0);
        chk("arst_cnt", retire_cnt, 32'h0);
        chk("arst_flags", {30'h0, halt, ready_out}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        send(1'b1, ALU, 5'd7, 32'h77, 32'h0);
        chk("h7_en", 32'(Wt_en), 32'h1);
        chk("h7_addr", 32'(Wt_addr), 32'h7);
        send(1'b1, HLT, 5'd0, 32'h0, 32'h0);
        chk("halt_set", 32'(halt), 32'h1);
        chk("halt_ready", 32'(ready_out), 32'h0);
        chk("halt_en", 32'(Wt_en), 32'h0);
        for (int i = 0; i < 10; i++) begin
            send(1'b1, (i == 4) ? HLT : ALU, 5'd8, 32'h88, 32'h0);
            chk("halted_en", 32'(Wt_en), 32'h0);
            chk("halted_cnt", retire_cnt, 32'h1);
            chk("halted_flag", 32'(halt), 32'h1);
        end

        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("unhalt_ready", 32'(ready_out), 32'h1);
        chk("unhalt_halt", 32'(halt), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1'b1, ALU, 5'd9, 32'h99, 32'h0);
        chk("resume_en", 32'(Wt_en), 32'h1);
        chk("resume_cnt", retire_cnt, 32'h1);

        rst = 1'b1;
        send(1'b1, ALU, 5'd10, 32'hAA, 32'h0);
        chk("rst_vs_hs_en", 32'(Wt_en), 32'h0);
        chk("rst_vs_hs_cnt", retire_cnt, 32'h0);
        rst = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
